// File: rtl/rr_sched_pkg.sv
// Shared types and sizing for the round-robin grant scheduler.
package rr_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating priority encoder: first set request at or above ptr, wrapping 7->0.
module rr_prio_enc8
  import rr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler with registered one-hot/binary grant outputs.
// Optional forced-release tenure limit is enabled by defining RR_TIMEOUT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; arbitrate when en=1 and any request is pending
// ST_GRANT   | grant held until rel, holder's request drops, or timeout
// ST_RELEASE | one dead cycle, pointer already advanced past the holder
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rel,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_param
    $error("rr_grant_scheduler: HOLD_MAX must be 1..2**CNT_W-1");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               hold_expired;

  rr_prio_enc8 u_prio_enc (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_oh_d    = gnt_oh_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (en && sel_found) begin
          state_d     = ST_GRANT;
          gnt_idx_d   = sel_idx;
          gnt_oh_d    = NUM_REQ'(1) << sel_idx;
          gnt_valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        // Outputs return to their idle values on the same edge the pointer moves.
        if (rel || !req[gnt_idx_q] || hold_expired) begin
          state_d     = ST_RELEASE;
          ptr_d       = gnt_idx_q + 1'b1;
          gnt_oh_d    = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_oh_q    <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_oh_q    <= gnt_oh_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  // Counter reads 1 during the first GRANT cycle and HOLD_MAX during the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= hold_expired;
      if (state_d == ST_GRANT)
        hold_cnt_q <= (state_q == ST_GRANT) ? hold_cnt_q + 1'b1 : CNT_W'(1);
      else
        hold_cnt_q <= '0;
    end
  end

  assign hold_expired = (state_q == ST_GRANT) && (hold_cnt_q == CNT_W'(HOLD_MAX));
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  assign gnt_oh    = gnt_oh_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: expected grant indices are queued
// when stimulus is applied and checked when gnt_valid rises.
module tb_rr_grant_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rel = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt_oh;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int exp_e;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  rr_grant_scheduler #(.HOLD_MAX(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .rel       (rel),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!gnt_valid && k < budget) begin
      step();
      k++;
    end
    if (!gnt_valid) chk("wait_gnt", 0, 1);
  endtask

  task automatic pulse_rel();
    rel = 1'b1;
    step();
    rel = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask

  always @(negedge clk) begin
    if (gnt_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("sb_idx", int'(gnt_idx), exp_e);
        chk("sb_oh", int'(gnt_oh), 1 << exp_e);
      end
    end
    prev_valid = gnt_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values
    do_reset();
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_oh", int'(gnt_oh), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_timeout", int'(timeout), 0);

    // two requesters, latency and 2-cycle gap
    en = 1'b1;
    req = 8'b0000_0101;
    exp_q.push_back(0);
    step();
    chk("lat_valid", int'(gnt_valid), 1);
    exp_q.push_back(2);
    pulse_rel();
    chk("gap_release", int'(gnt_valid), 0);
    step();
    chk("gap_idle", int'(gnt_valid), 0);
    step();
    chk("gap_regrant", int'(gnt_valid), 1);
    chk("second_idx", int'(gnt_idx), 2);
    req = 8'h00;
    step(3);

    // all requesters, full rotation with wrap
    do_reset();
    en = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) exp_q.push_back(i % 8);
    for (int i = 0; i < 9; i++) begin
      wait_valid(6);
      if (i == 8) req = 8'h00;
      pulse_rel();
    end
    step(3);

    // enable gating; en drop does not revoke
    do_reset();
    en = 1'b0;
    req = 8'hFF;
    step(5);
    chk("en0_valid", int'(gnt_valid), 0);
    en = 1'b1;
    exp_q.push_back(0);
    wait_valid(5);
    en = 1'b0;
    step(5);
    chk("en_drop_hold", int'(gnt_valid), 1);
    chk("en_drop_idx", int'(gnt_idx), 0);
    pulse_rel();
    step(4);
    chk("en0_blocked", int'(gnt_valid), 0);
    req = 8'h00;

    // holder 3 drops its request; pointer moves to 4
    do_reset();
    en = 1'b1;
    req = 8'h08;
    exp_q.push_back(3);
    wait_valid(5);
    req = 8'h2A;
    step(3);
    chk("other_req_hold", int'(gnt_valid), 1);
    chk("other_req_idx", int'(gnt_idx), 3);
    req = 8'h12;
    exp_q.push_back(4);
    step();
    chk("drop_release", int'(gnt_valid), 0);
    wait_valid(5);
    chk("ptr4_idx", int'(gnt_idx), 4);
    req = 8'h00;
    step(3);

    // tenure limit
    do_reset();
    en = 1'b1;
    req = 8'h04;
    exp_q.push_back(2);
    wait_valid(5);
`ifdef RR_TIMEOUT_EN
    step(14);
    chk("to_hold15", int'(gnt_valid), 1);
    chk("to_early", int'(timeout), 0);
    step();
    chk("to_release", int'(gnt_valid), 0);
    chk("to_pulse", int'(timeout), 1);
    req = 8'h00;
    step();
    chk("to_pulse_end", int'(timeout), 0);
    step(2);
`else
    step(20);
    chk("hold_forever", int'(gnt_valid), 1);
    chk("no_timeout", int'(timeout), 0);
    req = 8'h00;
    step(3);
`endif

    // async reset mid-grant
    do_reset();
    en = 1'b1;
    req = 8'hFF;
    exp_q.push_back(0);
    wait_valid(5);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(gnt_valid), 0);
    chk("arst_oh", int'(gnt_oh), 0);
    chk("arst_idx", int'(gnt_idx), 0);
    req = 8'h80;
    #2;
    rst_n = 1'b1;
    exp_q.push_back(7);
    wait_valid(6);
    chk("arst_regrant", int'(gnt_idx), 7);
    req = 8'h00;
    step(3);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
